// File: rtl/led_seq_pkg.sv
// Shared constants and types for the LED pattern sequencer.
package led_seq_pkg;

    localparam int LED_W = 8;
    localparam int PWM_W = 4;

    localparam logic [1:0] MODE_SHIFT  = 2'b00;
    localparam logic [1:0] MODE_BOUNCE = 2'b01;
    localparam logic [1:0] MODE_FILL   = 2'b10;
    localparam logic [1:0] MODE_FLASH  = 2'b11;

    localparam logic [LED_W-1:0] INIT_SHIFT  = 8'h01;
    localparam logic [LED_W-1:0] INIT_BOUNCE = 8'h01;
    localparam logic [LED_W-1:0] INIT_FILL   = 8'h00;
    localparam logic [LED_W-1:0] INIT_FLASH  = 8'h00;

    // Bounce endpoints, used to decide when the travel direction flips.
    localparam logic [LED_W-1:0] BOUNCE_TOP = 8'h80;
    localparam logic [LED_W-1:0] BOUNCE_BOT = 8'h01;

    typedef enum logic {
        B_LEFT  = 1'b0,
        B_RIGHT = 1'b1
    } bounce_t;

    // First pattern shown after a mode is loaded.
    function automatic logic [LED_W-1:0] init_pattern(input logic [1:0] m);
        logic [LED_W-1:0] p;
        case (m)
            MODE_SHIFT:  p = INIT_SHIFT;
            MODE_BOUNCE: p = INIT_BOUNCE;
            MODE_FILL:   p = INIT_FILL;
            default:     p = INIT_FLASH;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/led_pwm.sv
// Brightness PWM: free-running 16-step counter, brightness sampled only at
// the period boundary, and a registered gate on the LED bank.
module led_pwm
    import led_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PWM_W-1:0] brightness,
    input  logic [LED_W-1:0] pattern_in,
    output logic [LED_W-1:0] led
);

    localparam logic [PWM_W-1:0] PWM_MAX = '1;

    logic [PWM_W-1:0] pwm_cnt;
    logic [PWM_W-1:0] bright_q;
    logic             gate;

    // Full-scale brightness means always on rather than 15/16.
    assign gate = (pwm_cnt < bright_q) || (bright_q == PWM_MAX);

    // Counter, period-aligned brightness sample and gated LED register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_cnt  <= '0;
            bright_q <= PWM_MAX;
            led      <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (pwm_cnt == PWM_MAX) begin
                bright_q <= brightness;
            end
            led <= gate ? pattern_in : '0;
        end
    end

endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: rising-edge step detect on blink_in, per-mode
// pattern FSM, and the PWM brightness stage.
//
// bounce state | meaning
// B_LEFT       | lit LED travels toward bit 7
// B_RIGHT      | lit LED travels toward bit 0
module led_pattern_seq
    import led_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             blink_in,
    input  logic [1:0]       mode,
    input  logic             mode_load,
    input  logic [PWM_W-1:0] brightness,
    output logic [LED_W-1:0] led,
    output logic             step_pulse
);

    logic             prev_q;
    logic             step;
    logic             step_pulse_d;
    logic [1:0]       mode_q;
    logic [1:0]       mode_d;
    logic [LED_W-1:0] pattern_q;
    logic [LED_W-1:0] pattern_d;
    bounce_t          bstate_q;
    bounce_t          bstate_d;

    // prev_q resets high so a level already high at release is not a step.
    assign step = blink_in & ~prev_q;

    // State register: edge-detect history, mode, pattern and bounce direction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q     <= 1'b1;
            mode_q     <= MODE_SHIFT;
            pattern_q  <= INIT_SHIFT;
            bstate_q   <= B_LEFT;
            step_pulse <= 1'b0;
        end else begin
            prev_q     <= blink_in;
            mode_q     <= mode_d;
            pattern_q  <= pattern_d;
            bstate_q   <= bstate_d;
            step_pulse <= step_pulse_d;
        end
    end

    // Next state: a mode load takes priority over (and swallows) a step.
    always_comb begin
        mode_d    = mode_q;
        pattern_d = pattern_q;
        bstate_d  = bstate_q;
        if (mode_load) begin
            mode_d    = mode;
            pattern_d = init_pattern(mode);
            bstate_d  = B_LEFT;
        end else if (step) begin
            case (mode_q)
                MODE_SHIFT: begin
                    pattern_d = {pattern_q[LED_W-2:0], pattern_q[LED_W-1]};
                end
                MODE_BOUNCE: begin
                    if (bstate_q == B_LEFT) begin
                        pattern_d = pattern_q << 1;
                        if (pattern_d == BOUNCE_TOP) begin
                            bstate_d = B_RIGHT;
                        end
                    end else begin
                        pattern_d = pattern_q >> 1;
                        if (pattern_d == BOUNCE_BOT) begin
                            bstate_d = B_LEFT;
                        end
                    end
                end
                MODE_FILL: begin
                    pattern_d = (pattern_q == '1) ? '0 : {pattern_q[LED_W-2:0], 1'b1};
                end
                default: begin
                    pattern_d = ~pattern_q;
                end
            endcase
        end
    end

    // Output decode: strobe only for steps that actually advanced the pattern.
    always_comb begin
        step_pulse_d = step & ~mode_load;
    end

    led_pwm u_pwm (
        .clk        (clk),
        .rst_n      (rst_n),
        .brightness (brightness),
        .pattern_in (pattern_q),
        .led        (led)
    );

endmodule
